// File: rtl/cdc_pkg.sv
// Shared CDC constants and helpers for the synchroniser/filter blocks.
package cdc_pkg;

   localparam int SYNC_STAGES_MIN = 2;

   // Ceiling log2, with clog2(1) == 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Single-bit flop-chain synchroniser; depth is clamped to at least SYNC_STAGES_MIN.
module sync_chain
   import cdc_pkg::*;
#(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic async_bit,
   output logic sync_bit
);

   localparam int N = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

   logic [N-1:0] chain;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) chain <= {N{RST_VAL}};
      else          chain <= {chain[N-2:0], async_bit};
   end

   assign sync_bit = chain[N-1];

endmodule

// File: rtl/sync_filter_bank.sv
// Multi-channel CDC synchroniser with per-channel stability filter and edge pulses.
// Optional macro SYNC_EDGE_DET_EN enables the rise_o/fall_o edge detectors.
module sync_filter_bank
   import cdc_pkg::*;
#(
   parameter int                CH_NUM        = 4,
   parameter int                SYNC_STAGES   = 2,
   parameter int                FILTER_CYCLES = 4,
   parameter logic [CH_NUM-1:0] RESET_VAL     = '0
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              en_i,
   input  logic [CH_NUM-1:0] data_async_i,
   output logic [CH_NUM-1:0] data_synced_o,
   output logic [CH_NUM-1:0] data_filt_o,
   output logic [CH_NUM-1:0] rise_o,
   output logic [CH_NUM-1:0] fall_o
);

   logic [CH_NUM-1:0] synced;

`ifdef SYNC_EDGE_DET_EN
   logic [CH_NUM-1:0] rise;
   logic [CH_NUM-1:0] fall;
   assign rise_o = rise;
   assign fall_o = fall;
`else
   assign rise_o = '0;
   assign fall_o = '0;
`endif

   assign data_synced_o = synced;

   for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
      sync_chain #(
         .STAGES  (SYNC_STAGES),
         .RST_VAL (RESET_VAL[ch])
      ) u_chain (
         .clk_i     (clk_i),
         .rst_n_i   (rst_n_i),
         .async_bit (data_async_i[ch]),
         .sync_bit  (synced[ch])
      );

      if (FILTER_CYCLES == 0) begin : g_bypass
         logic unused_en;
         assign unused_en       = en_i;
         assign data_filt_o[ch] = synced[ch];

`ifdef SYNC_EDGE_DET_EN
         // Edges come from the raw synced level against its previous value.
         logic prev_q;
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) prev_q <= RESET_VAL[ch];
            else          prev_q <= synced[ch];
         end
         assign rise[ch] = synced[ch] & ~prev_q;
         assign fall[ch] = ~synced[ch] & prev_q;
`endif
      end else begin : g_filter
         localparam int             CW   = (clog2(FILTER_CYCLES + 1) < 1) ? 1 : clog2(FILTER_CYCLES + 1);
         localparam logic [CW-1:0] TERM = CW'(FILTER_CYCLES - 1);

         logic [CW-1:0] cnt_q, cnt_d;
         logic          filt_q, filt_d;

         // Any cycle of agreement (or disable) restarts qualification from zero.
         always_comb begin
            cnt_d  = '0;
            filt_d = filt_q;
            if (en_i && (synced[ch] != filt_q)) begin
               if (cnt_q == TERM) filt_d = synced[ch];
               else               cnt_d  = cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               cnt_q  <= '0;
               filt_q <= RESET_VAL[ch];
            end else begin
               cnt_q  <= cnt_d;
               filt_q <= filt_d;
            end
         end

         assign data_filt_o[ch] = filt_q;

`ifdef SYNC_EDGE_DET_EN
         // Registered off the next filtered value so the pulse aligns with the new level.
         logic rise_q, fall_q;
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               rise_q <= 1'b0;
               fall_q <= 1'b0;
            end else begin
               rise_q <= filt_d & ~filt_q;
               fall_q <= ~filt_d & filt_q;
            end
         end
         assign rise[ch] = rise_q;
         assign fall[ch] = fall_q;
`endif
      end
   end

endmodule
